// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected output streamer.
//   acc_w   : accumulator width derived from activation width and fan-in
//   sat_max : largest non-negative activation for a given width
//   state_e : streamer FSM states
package fc_pkg;

  typedef enum logic [0:0] {IDLE, STREAM} state_e;

  function automatic int unsigned acc_w(input int unsigned width, input int unsigned fan_in);
    return width * 2 + $clog2(fan_in);
  endfunction

  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Requantizes one accumulator value by round, shift and saturate.
//   i_v   : signed accumulator value (ACC_W bits)
//   o_q   : unsigned activation, 0..2^(WIDTH-1)-1
//   o_sat : value was clipped to the maximum (never set for negative inputs)
module fc_requant import fc_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 23,
  parameter int unsigned SHIFT = 7
) (
  input  logic [ACC_W-1:0] i_v,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sat
);

  // Rounding bit position; SHIFT=0 has no rounding term at all.
  localparam int unsigned    RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND     = (SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_POS) : '0;
  localparam logic [ACC_W:0] MAX_Q   = (ACC_W + 1)'(sat_max(WIDTH));

  logic [ACC_W:0] w_sum;
  logic [ACC_W:0] w_r;

  // One extra bit so the rounding add cannot wrap.
  assign w_sum = {1'b0, i_v} + RND;
  assign w_r   = w_sum >> SHIFT;

  always_comb begin
    o_q   = '0;
    o_sat = 1'b0;
    if (!i_v[ACC_W-1]) begin
      if (w_r > MAX_Q) begin
        o_q   = MAX_Q[WIDTH-1:0];
        o_sat = 1'b1;
      end else begin
        o_q   = w_r[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fc_out_streamer.sv
// Captures all N_OUT neuron accumulators in one handshake, requantizes them
// and streams them out one neuron per beat.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : frame capture handshake; in_z is the frame
//   out_valid/out_ready : output beat handshake
//   out_data, out_idx   : requantized activation and its neuron index
//   out_last            : beat carries the final neuron
//   sat_flag            : some element of the current frame saturated
module fc_out_streamer import fc_pkg::*; #(
  parameter int unsigned  WIDTH = 8,
  parameter int unsigned  IN    = 128,
  parameter int unsigned  N_OUT = 10,
  parameter int unsigned  SHIFT = 7,
  localparam int unsigned ACC_W = acc_w(WIDTH, IN),
  localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_z [N_OUT],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             sat_flag
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  logic [WIDTH-1:0] w_q [N_OUT];
  logic [N_OUT-1:0] w_sat;
  logic [IDX_W-1:0] w_idx_nxt;

  state_e           r_state;
  logic [WIDTH-1:0] r_buf [N_OUT];
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic             r_sat;

  for (genvar g = 0; g < N_OUT; g++) begin : g_requant
    fc_requant #(
      .WIDTH(WIDTH),
      .ACC_W(ACC_W),
      .SHIFT(SHIFT)
    ) u_requant (
      .i_v  (in_z[g]),
      .o_q  (w_q[g]),
      .o_sat(w_sat[g])
    );
  end

  assign w_idx_nxt = r_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sat   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_OUT; i++) r_buf[i] <= w_q[i];
            r_sat   <= |w_sat;
            r_idx   <= '0;
            r_valid <= 1'b1;
            // First beat is presented straight from the requantizers.
            r_data  <= w_q[0];
            r_last  <= (N_OUT == 1);
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state <= IDLE;
              r_idx   <= '0;
              r_valid <= 1'b0;
              r_data  <= '0;
              r_last  <= 1'b0;
            end else begin
              r_idx   <= w_idx_nxt;
              r_data  <= r_buf[w_idx_nxt];
              r_last  <= (w_idx_nxt == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign sat_flag  = r_sat;

endmodule

// File: tb/tb_fc_out_streamer.sv
module tb_fc_out_streamer;

  localparam int ACC_W = 23;

  logic             clk = 1'b0;
  logic             rst;
  always #5 clk = ~clk;

  // Default build: WIDTH=8, IN=128, N_OUT=10, SHIFT=7
  logic             in_valid, in_ready, out_valid, out_ready, out_last, sat_flag;
  logic [ACC_W-1:0] in_z [10];
  logic [7:0]       out_data;
  logic [3:0]       out_idx;

  // Small build: N_OUT=1, SHIFT=0
  logic             in_valid1, in_ready1, out_valid1, out_ready1, out_last1, sat_flag1;
  logic [ACC_W-1:0] in_z1 [1];
  logic [7:0]       out_data1;
  logic [0:0]       out_idx1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ACC_W-1:0] fr_round [10] = '{23'd0, 23'd63, 23'd64, 23'd191, 23'd16256,
                                      23'd100, 23'd200, 23'd300, 23'd8000, 23'd16319};
  logic [7:0]       ex_round [10] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd127,
                                      8'd1, 8'd2, 8'd2, 8'd63, 8'd127};
  logic [ACC_W-1:0] fr_sat   [10] = '{23'd16320, 23'h3FFFFF, 23'h400000, 23'h7FFFFF, 23'd16383,
                                      23'd1000, 23'd0, 23'd0, 23'd0, 23'd0};
  logic [7:0]       ex_sat   [10] = '{8'd127, 8'd127, 8'd0, 8'd0, 8'd127,
                                      8'd8, 8'd0, 8'd0, 8'd0, 8'd0};

  fc_out_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_z     (in_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .sat_flag (sat_flag)
  );

  fc_out_streamer #(
    .WIDTH(8),
    .IN   (128),
    .N_OUT(1),
    .SHIFT(0)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .in_z     (in_z1),
    .out_valid(out_valid1),
    .out_ready(out_ready1),
    .out_data (out_data1),
    .out_idx  (out_idx1),
    .out_last (out_last1),
    .sat_flag (sat_flag1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input bit use_sat);
    for (int i = 0; i < 10; i++) in_z[i] = use_sat ? fr_sat[i] : fr_round[i];
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    for (int i = 0; i < 10; i++) in_z[i] = '0;
    in_z1[0] = '0;
    #1;
    n_checks++;
    if ({out_valid, out_idx, out_data, out_last, sat_flag} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs got %0h exp 0",
                         {out_valid, out_idx, out_data, out_last, sat_flag});
    end
    repeat (2) cyc();
    @(negedge clk) rst = 1'b0;
    cyc();
    n_checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release in_ready got %b/%b valid %b exp 1/1 0",
                         in_ready, in_ready1, out_valid);
    end
    // Reset in the middle of a saturating frame.
    load_frame(1'b1); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    n_checks++;
    if (out_idx !== 4'd2 || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL mid_frame_pre idx got %0d sat %b exp 2 1", out_idx, sat_flag);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_idx, out_data, out_last, sat_flag} !== 15'd0) begin
      n_fail++; $display("FAIL mid_frame_reset got %0h exp 0",
                         {out_valid, out_idx, out_data, out_last, sat_flag});
    end
    @(negedge clk) rst = 1'b0;
    cyc();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset in_ready got %b valid %b exp 1 0", in_ready, out_valid);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_partial_beats valid got %b exp 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_rounding();
    out_ready = 1'b1; load_frame(1'b0); in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL round_in_ready got %b exp 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_data !== ex_round[i] ||
          out_last !== (i == 9) || sat_flag !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL round_beat%0d got v%b i%0d d%0d l%b s%b r%b exp v1 i%0d d%0d l%b s0 r0",
                 i, out_valid, out_idx, out_data, out_last, sat_flag, in_ready,
                 i, ex_round[i], (i == 9));
      end
      cyc();
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL round_end got v%b l%b r%b exp v0 l0 r1",
                         out_valid, out_last, in_ready);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; load_frame(1'b1); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_data !== ex_sat[i] ||
          sat_flag !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_beat%0d got v%b i%0d d%0d s%b exp v1 i%0d d%0d s1",
                 i, out_valid, out_idx, out_data, sat_flag, i, ex_sat[i]);
      end
      cyc();
    end
    n_checks++;
    if (out_valid !== 1'b0 || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold got v%b s%b exp v0 s1", out_valid, sat_flag);
    end
  endtask

  task automatic test_backpressure();
    int         hs;
    bit         held;
    logic [7:0] pd;
    logic [3:0] pi;
    logic       pl;
    hs = 0; held = 1'b0; pd = '0; pi = '0; pl = 1'b0;
    out_ready = 1'b0; load_frame(1'b0); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 300 && hs < 10; c++) begin
      if (held) begin
        n_checks++;
        if (out_data !== pd || out_idx !== pi || out_last !== pl) begin
          n_fail++; $display("FAIL bp_stable got d%0d i%0d l%b exp d%0d i%0d l%b",
                             out_data, out_idx, out_last, pd, pi, pl);
        end
      end
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_stream got v%b r%b exp v1 r0", out_valid, in_ready);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_ready) begin
        n_checks++;
        if (out_idx !== 4'(hs) || out_data !== ex_round[hs] || out_last !== (hs == 9)) begin
          n_fail++; $display("FAIL bp_beat%0d got i%0d d%0d l%b exp i%0d d%0d l%b",
                             hs, out_idx, out_data, out_last, hs, ex_round[hs], (hs == 9));
        end
        hs++;
        held = 1'b0;
      end else begin
        held = 1'b1; pd = out_data; pi = out_idx; pl = out_last;
      end
      cyc();
    end
    out_ready = 1'b0;
    n_checks++;
    if (hs !== 10 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_count got hs%0d v%b r%b exp hs10 v0 r1",
                         hs, out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; load_frame(1'b1); in_valid = 1'b1;
    cyc();
    // Changes while streaming must be ignored until the next capture.
    load_frame(1'b0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_data !== ex_sat[i] ||
          sat_flag !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL b2b_a%0d got v%b i%0d d%0d s%b r%b exp v1 i%0d d%0d s1 r0",
                           i, out_valid, out_idx, out_data, sat_flag, in_ready, i, ex_sat[i]);
      end
      cyc();
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap got v%b r%b s%b exp v0 r1 s1",
                         out_valid, in_ready, sat_flag);
    end
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_data !== ex_round[i] ||
          sat_flag !== 1'b0) begin
        n_fail++; $display("FAIL b2b_b%0d got v%b i%0d d%0d s%b exp v1 i%0d d%0d s0",
                           i, out_valid, out_idx, out_data, sat_flag, i, ex_round[i]);
      end
      cyc();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end valid got %b exp 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_small();
    in_z1[0] = 23'd100; in_valid1 = 1'b1; out_ready1 = 1'b0;
    cyc();
    in_valid1 = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'd100 || out_last1 !== 1'b1 ||
        out_idx1 !== 1'b0 || sat_flag1 !== 1'b0) begin
      n_fail++; $display("FAIL small_100 got v%b d%0d l%b i%0d s%b exp v1 d100 l1 i0 s0",
                         out_valid1, out_data1, out_last1, out_idx1, sat_flag1);
    end
    cyc();
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'd100) begin
      n_fail++; $display("FAIL small_hold got v%b d%0d exp v1 d100", out_valid1, out_data1);
    end
    out_ready1 = 1'b1;
    cyc();
    out_ready1 = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b0 || out_last1 !== 1'b0) begin
      n_fail++; $display("FAIL small_done got v%b l%b exp v0 l0", out_valid1, out_last1);
    end
    in_z1[0] = 23'd128; in_valid1 = 1'b1;
    cyc();
    in_valid1 = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'd127 || out_last1 !== 1'b1 ||
        sat_flag1 !== 1'b1) begin
      n_fail++; $display("FAIL small_128 got v%b d%0d l%b s%b exp v1 d127 l1 s1",
                         out_valid1, out_data1, out_last1, sat_flag1);
    end
    out_ready1 = 1'b1;
    cyc();
    out_ready1 = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b0 || sat_flag1 !== 1'b1) begin
      n_fail++; $display("FAIL small_end got v%b s%b exp v0 s1", out_valid1, sat_flag1);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
